// File: rtl/picomem_wb_bridge.sv
// picomem_wb_bridge: PicoMem responder turning each CPU access into one Wishbone B4 classic single read/write.
// Optional bus timeout enabled by defining PICOWB_TIMEOUT_EN.
module picomem_wb_bridge #(
    parameter logic [31:0] ADDR_BASE      = 32'hC000_0000,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_s_valid,
    output logic        mem_s_ready,
    input  logic [31:0] mem_s_addr,
    input  logic [31:0] mem_s_wdata,
    input  logic [3:0]  mem_s_wstrb,
    output logic [31:0] mem_s_rdata,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [29:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic [7:0]  err_count
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state;
    logic   tmo_hit;
    logic   fail;
    logic   term;
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end
`ifdef PICOWB_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    // Counts BUS cycles already spent; the last allowed cycle forces termination.
    always_ff @(posedge clk) begin
        if (reset) tmo_cnt <= '0;
        else tmo_cnt <= (state == BUS) ? tmo_cnt + 16'd1 : 16'd0;
    end
    assign tmo_hit = (state == BUS) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif
    // A real ack beats a simultaneous timeout; err and timeout terminate identically.
    assign fail     = wb_err_i | (tmo_hit & ~wb_ack_i);
    assign term     = wb_ack_i | fail;
    assign wb_stb_o = wb_cyc_o;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_s_ready <= 1'b0;
            mem_s_rdata <= '0;
            wb_cyc_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            err_count   <= '0;
        end else begin
            case (state)
                IDLE: if (mem_s_valid) begin
                    state    <= BUS;
                    wb_cyc_o <= 1'b1;
                    wb_we_o  <= |mem_s_wstrb;
                    wb_sel_o <= (|mem_s_wstrb) ? mem_s_wstrb : 4'hF;
                    wb_adr_o <= 30'((mem_s_addr - ADDR_BASE) >> 2);
                    wb_dat_o <= mem_s_wdata;
                end
                BUS: if (term) begin
                    state       <= RESP;
                    wb_cyc_o    <= 1'b0;
                    mem_s_ready <= 1'b1;
                    mem_s_rdata <= fail ? ERR_RDATA : (wb_we_o ? 32'd0 : wb_dat_i);
                    if (fail && err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
                default: begin
                    state       <= IDLE;
                    mem_s_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_picomem_wb_bridge.sv
// tb_picomem_wb_bridge: directed bench with a cycle-level expectation model for picomem_wb_bridge.
module tb_picomem_wb_bridge;
    localparam logic [31:0] BASE = 32'hC000_0000;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_s_valid = 1'b0;
    logic        mem_s_ready;
    logic [31:0] mem_s_addr = '0;
    logic [31:0] mem_s_wdata = '0;
    logic [3:0]  mem_s_wstrb = '0;
    logic [31:0] mem_s_rdata;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = 32'h5555_AAAA;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [7:0]  err_count;
    int errors = 0;
    int checks = 0;
    logic        exp_cyc = 1'b0, exp_ready = 1'b0, exp_we = 1'b0;
    logic [29:0] exp_adr = '0;
    logic [3:0]  exp_sel = '0;
    logic [31:0] exp_dat = '0, exp_rdata = '0;
    int          exp_errs = 0;
    logic [31:0] got_rdata;
    logic [29:0] cap_adr;
    logic [3:0]  cap_sel;
    logic        cap_we;
    int          cur_len = 0, last_len = 0;

    picomem_wb_bridge #(.ADDR_BASE(BASE), .ERR_RDATA(ERRD), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .mem_s_valid(mem_s_valid), .mem_s_ready(mem_s_ready), .mem_s_addr(mem_s_addr),
        .mem_s_wdata(mem_s_wdata), .mem_s_wstrb(mem_s_wstrb), .mem_s_rdata(mem_s_rdata),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Per-cycle comparison against the expectation model.
    always @(negedge clk) begin
        check("cyc", 32'(wb_cyc_o), 32'(exp_cyc));
        check("stb", 32'(wb_stb_o), 32'(exp_cyc));
        check("ready", 32'(mem_s_ready), 32'(exp_ready));
        check("err_count", 32'(err_count), 32'(exp_errs));
        if (exp_cyc) begin
            check("adr", 32'(wb_adr_o), 32'(exp_adr));
            check("sel", 32'(wb_sel_o), 32'(exp_sel));
            check("we", 32'(wb_we_o), 32'(exp_we));
            check("dat_o", wb_dat_o, exp_dat);
        end
        if (exp_ready) check("rdata", mem_s_rdata, exp_rdata);
        if (wb_cyc_o) cur_len++;
        else if (cur_len != 0) begin
            last_len = cur_len;
            cur_len = 0;
        end
    end

    task automatic start(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] off;
        off = a - BASE;
        mem_s_valid = 1'b1;
        mem_s_addr = a;
        mem_s_wdata = wd;
        mem_s_wstrb = ws;
        exp_adr = off[31:2];
        exp_we = |ws;
        exp_sel = (|ws) ? ws : 4'hF;
        exp_dat = wd;
        @(posedge clk); #1;
        exp_cyc = 1'b1;
        @(negedge clk);
        cap_adr = wb_adr_o;
        cap_sel = wb_sel_o;
        cap_we = wb_we_o;
    endtask

    task automatic finish_resp(input logic failed, input logic [31:0] rd);
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h5555_AAAA;
        exp_cyc = 1'b0;
        exp_ready = 1'b1;
        exp_rdata = rd;
        if (failed && exp_errs < 255) exp_errs++;
        @(negedge clk);
        got_rdata = mem_s_rdata;
        @(posedge clk); #1;
        mem_s_valid = 1'b0;
        exp_ready = 1'b0;
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int waits, input logic ack, input logic err, input logic [31:0] sd);
        start(a, wd, ws);
        repeat (waits) begin
            @(posedge clk); #1;
        end
        wb_ack_i = ack;
        wb_err_i = err;
        wb_dat_i = sd;
        finish_resp(err, err ? ERRD : ((|ws) ? 32'd0 : sd));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mem_s_valid = 1'b0;
        exp_cyc = 1'b0;
        exp_ready = 1'b0;
        exp_errs = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_rdata", mem_s_rdata, 32'd0);
        check("rst_adr", 32'(wb_adr_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'd0);
        check("rst_we", 32'(wb_we_o), 32'd0);
        @(posedge clk); #1;
        access(32'hC000_0010, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h1234_5678);
        check("rd0_adr", 32'(cap_adr), 32'h4);
        check("rd0_sel", 32'(cap_sel), 32'hF);
        check("rd0_we", 32'(cap_we), 32'd0);
        check("rd0_data", got_rdata, 32'h1234_5678);
        check("rd0_len", last_len, 1);
        access(32'hC000_0102, 32'h00AB_0000, 4'b0100, 5, 1'b1, 1'b0, 32'h9999_9999);
        check("wr_adr", 32'(cap_adr), 32'h40);
        check("wr_sel", 32'(cap_sel), 32'h4);
        check("wr_we", 32'(cap_we), 32'd1);
        check("wr_len", last_len, 6);
        access(32'hC000_0020, 32'h0, 4'h0, 1, 1'b1, 1'b1, 32'h0BAD_0BAD);
        check("err_rdata", got_rdata, 32'hDEAD_BEEF);
        check("err_cnt1", 32'(err_count), 32'd1);
        start(32'hC000_0030, 32'h0, 4'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mem_s_valid = 1'b0;
        exp_cyc = 1'b0;
        exp_errs = 0;
        @(negedge clk);
        check("abort_cnt", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        access(32'hC000_0034, 32'h0, 4'h0, 2, 1'b1, 1'b0, 32'h0A0B_0C0D);
        check("post_abort", got_rdata, 32'h0A0B_0C0D);
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        @(posedge clk); #1;
        access(32'hC000_0FFC, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'hCAFE_F00D);
        check("stray_rd", got_rdata, 32'hCAFE_F00D);
        check("stray_cnt", 32'(err_count), 32'd0);
        access(32'h0000_0007, 32'h1122_3344, 4'b1001, 2, 1'b1, 1'b0, 32'h0);
        check("wrap_adr", 32'(cap_adr), 32'h1000_0001);
        check("wrap_sel", 32'(cap_sel), 32'h9);
        for (int i = 0; i < 6; i++)
            access(BASE + 32'(i * 68), 32'(i) * 32'h0101_0101, 4'(i * 3), i % 3, 1'b1, 1'b0, 32'hF000_0000 + 32'(i));
        for (int i = 0; i < 300; i++)
            access(32'hC000_0100, 32'h0, 4'h0, 0, 1'b0, 1'b1, 32'h0);
        check("sat_cnt", 32'(err_count), 32'd255);
        do_reset();
`ifdef PICOWB_TIMEOUT_EN
        start(32'hC000_0200, 32'h0, 4'h0);
        repeat (7) begin
            @(posedge clk); #1;
        end
        finish_resp(1'b1, ERRD);
        check("tmo_len", last_len, 8);
        check("tmo_rdata", got_rdata, 32'hDEAD_BEEF);
        check("tmo_cnt", 32'(err_count), 32'd1);
`else
        start(32'hC000_0200, 32'h0, 4'h0);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("hang_cyc", 32'(wb_cyc_o), 32'd1);
        @(posedge clk); #1;
        do_reset();
`endif
        @(posedge clk); #1;
        access(32'hC000_0044, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h7777_1234);
        check("final_rd", got_rdata, 32'h7777_1234);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
